mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control unit: Moore FSM sequencing the shared-memory multicycle datapath
//  (PC, IR, regfile, ALU, unified instr/data memory) through fetch/decode/execute/writeback.
//  Supports RTYPE, LW, SW, BEQ, ADDI, J; the ALU function decode remains in the existing aludec.
//  Stalls on a memory-ready handshake; traps illegal opcodes.
// PARAMETERS
//  STATE_W       4   width of state register / dbg_state port (13 states used)
//  ILLEGAL_TRAP  1   1: illegal op -> EXC state (pulses illegal_op); 0: illegal op -> FETCH silently
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  synchronous, active-high
//  op         in   6  IR[31:26]; sampled in DECODE and MEMADR
//  zero       in   1  ALU zero flag (valid in BEQEX)
//  mem_ready  in   1  memory access completes this cycle
//  iord       out  1  memory address select: 0=PC, 1=ALUOut
//  irwrite    out  1  IR load enable
//  memwrite   out  1  memory write strobe
//  memtoreg   out  1  regfile write data: 0=ALUOut, 1=MDR
//  regdst     out  1  regfile write address: 0=rt, 1=rd
//  regwrite   out  1  regfile write enable
//  alusrca    out  1  ALU A: 0=PC, 1=regA
//  alusrcb    out  2  ALU B: 00=regB 01=4 10=signimm 11=signimm<<2
//  aluop      out  2  to aludec: 00=add 01=sub 10=funct
//  pcsrc      out  2  PC next: 00=ALUResult 01=ALUOut 10=jump target
//  pcen       out  1  PC load = pcwrite | (branch & zero)
//  illegal_op out  1  one-cycle pulse in EXC
//  dbg_state  out  STATE_W  current state encoding
// BEHAVIOUR
//  - Reset: state<=FETCH on next edge; while reset=1 all enables (irwrite, memwrite, regwrite,
//    pcen, illegal_op) forced 0. Reset mid-instruction aborts it; no partial writeback.
//  - Outputs are pure functions of state (plus mem_ready/zero gating below); unlisted outputs 0.
//  - States / outputs / next state:
//    FETCH   iord=0 alusrcb=01 aluop=00 pcsrc=00; irwrite=pcwrite=mem_ready -> DECODE if mem_ready else FETCH
//    DECODE  alusrcb=11 aluop=00 -> by op: LW/SW MEMADR, RTYPE RTYPEEX, BEQ BEQEX, ADDI ADDIEX,
//            J JEX, other EXC (ILLEGAL_TRAP=1) / FETCH (=0)
//    MEMADR  alusrca=1 alusrcb=10 -> LW MEMRD, SW MEMWR
//    MEMRD   iord=1 -> MEMWB if mem_ready else MEMRD
//    MEMWB   memtoreg=1 regdst=0 regwrite=1 -> FETCH
//    MEMWR   iord=1 memwrite=1 (held until ready) -> FETCH if mem_ready else MEMWR
//    RTYPEEX alusrca=1 alusrcb=00 aluop=10 -> RTYPEWB
//    RTYPEWB regdst=1 memtoreg=0 regwrite=1 -> FETCH
//    BEQEX   alusrca=1 alusrcb=00 aluop=01 pcsrc=01 branch=1 -> FETCH
//    ADDIEX  alusrca=1 alusrcb=10 aluop=00 -> ADDIWB
//    ADDIWB  regdst=0 memtoreg=0 regwrite=1 -> FETCH
//    JEX     pcsrc=10 pcwrite=1 -> FETCH
//    EXC     illegal_op=1 -> FETCH (PC already advanced by FETCH)
//  - Latency with mem_ready=1 throughout: J/BEQ 3, RTYPE/ADDI/SW 4, LW 5 cycles.
//    Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle; no other state waits.
//  - pcwrite/irwrite never asserted in FETCH without mem_ready (no double PC increment).
//  - Unused state encodings -> FETCH next cycle, all enables 0.
// STRUCTURE
//  - Shared package mips_pkg: opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011,
//    OP_BEQ 000100, OP_ADDI 001000, OP_J 000010), ALUOP_* and state encodings.
//  - One sub-module: mc_outdec (combinational state -> control word); next-state logic and
//    state register stay in mc_controller; pcen gating in mc_controller.
// TESTING
//  - Reset held 2 cycles mid-LW (in MEMRD) -> regwrite stays 0; dbg_state=FETCH after release.
//  - op=000000, mem_ready=1 -> FETCH,DECODE,RTYPEEX,RTYPEWB; regwrite=1 regdst=1 only in cycle 4.
//  - op=100011, mem_ready low 2 cycles in MEMRD -> LW takes 7 cycles; memtoreg=regwrite=1 once.
//  - op=000100, zero=1 -> pcen=1 pcsrc=01 in BEQEX; repeat zero=0 -> pcen=0 in BEQEX.
//  - mem_ready=0 for 3 cycles in FETCH -> irwrite=pcwrite=pcen=0 those cycles, 1 on ready cycle.
//  - op=111111 -> DECODE,EXC with illegal_op=1 one cycle, then FETCH; ILLEGAL_TRAP=0 -> no pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU/mux selects,
// controller state encodings and the decoded control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11,
    ST_EXC     = 4'd12
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-word decode: maps the controller state (and mem_ready in the
// wait states) onto the datapath control word. Unused encodings decode to all-zero.
module mc_outdec
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        // PC and IR update only on the cycle the instruction word arrives
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      ST_MEMRD: ctrl.iord = 1'b1;
      ST_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      ST_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      ST_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_ADDIWB: ctrl.regwrite = 1'b1;
      ST_JEX: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      ST_EXC: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencer for fetch/decode/execute/writeback with a
// memory-ready stall handshake and an optional illegal-opcode trap state.
module mc_controller
  import mips_pkg::*;
#(
  parameter int STATE_W      = 4,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               irwrite,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPEEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JEX;
          default:      state_d = ILLEGAL_TRAP ? ST_EXC : ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:   state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTYPEEX: state_d = ST_RTYPEWB;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Write enables are held off during reset so an aborted instruction leaves no side effects
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite & ~reset;
  assign memwrite   = ctrl.memwrite & ~reset;
  assign memtoreg   = ctrl.memtoreg;
  assign regdst     = ctrl.regdst;
  assign regwrite   = ctrl.regwrite & ~reset;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign pcsrc      = ctrl.pcsrc;
  assign pcen       = (ctrl.pcwrite | (ctrl.branch & zero)) & ~reset;
  assign illegal_op = ctrl.illegal_op & ~reset;
  assign dbg_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus a randomized instruction
// stream checked cycle-by-cycle against an instruction-level phase model.
module tb_mc_controller;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op;

  logic iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] dbg_state;

  logic iord_0, irwrite_0, memwrite_0, memtoreg_0, regdst_0, regwrite_0, alusrca_0, pcen_0;
  logic illegal_op_0;
  logic [1:0] alusrcb_0, aluop_0, pcsrc_0;
  logic [3:0] dbg_state_0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mc_controller #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  mc_controller #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) dut_notrap (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord_0), .irwrite(irwrite_0), .memwrite(memwrite_0), .memtoreg(memtoreg_0),
    .regdst(regdst_0), .regwrite(regwrite_0), .alusrca(alusrca_0), .alusrcb(alusrcb_0),
    .aluop(aluop_0), .pcsrc(pcsrc_0), .pcen(pcen_0), .illegal_op(illegal_op_0),
    .dbg_state(dbg_state_0)
  );

  typedef enum {PH_F, PH_D, PH_ADR, PH_RD, PH_LWB, PH_WR, PH_RX, PH_RWB,
                PH_BEQ, PH_AX, PH_AWB, PH_J, PH_EXC} ph_e;

  ph_e         ph_q[$];
  logic [18:0] obs_q[$];
  logic [18:0] exp_q[$];
  logic [4:0]  obs0_q[$];
  int          lat_obs;

  function automatic logic [18:0] obs_vec();
    return {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca,
            alusrcb, aluop, pcsrc, pcen, illegal_op, dbg_state};
  endfunction

  // Expected control word for one phase, straight from the state/output table
  function automatic logic [18:0] exp_vec(ph_e ph, logic rdy, logic z);
    logic io = 0, irw = 0, mw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, pe = 0, il = 0;
    logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
    logic [3:0] st = 4'd0;
    case (ph)
      PH_F:   begin sb = 2'b01; irw = rdy; pe = rdy; st = ST_FETCH; end
      PH_D:   begin sb = 2'b11; st = ST_DECODE; end
      PH_ADR: begin sa = 1; sb = 2'b10; st = ST_MEMADR; end
      PH_RD:  begin io = 1; st = ST_MEMRD; end
      PH_LWB: begin m2r = 1; rw = 1; st = ST_MEMWB; end
      PH_WR:  begin io = 1; mw = 1; st = ST_MEMWR; end
      PH_RX:  begin sa = 1; ao = 2'b10; st = ST_RTYPEEX; end
      PH_RWB: begin rd = 1; rw = 1; st = ST_RTYPEWB; end
      PH_BEQ: begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; st = ST_BEQEX; end
      PH_AX:  begin sa = 1; sb = 2'b10; st = ST_ADDIEX; end
      PH_AWB: begin rw = 1; st = ST_ADDIWB; end
      PH_J:   begin ps = 2'b10; pe = 1; st = ST_JEX; end
      PH_EXC: begin il = 1; st = ST_EXC; end
      default: ;
    endcase
    return {io, irw, mw, m2r, rd, rw, sa, sb, ao, ps, pe, il, st};
  endfunction

  function automatic int lat_base(logic [5:0] o);
    case (o)
      OP_J, OP_BEQ:             return 3;
      OP_RTYPE, OP_ADDI, OP_SW: return 4;
      OP_LW:                    return 5;
      default:                  return 3;
    endcase
  endfunction

  function automatic void build_phases(logic [5:0] o);
    ph_q = {PH_F, PH_D};
    case (o)
      OP_LW:    begin ph_q.push_back(PH_ADR); ph_q.push_back(PH_RD); ph_q.push_back(PH_LWB); end
      OP_SW:    begin ph_q.push_back(PH_ADR); ph_q.push_back(PH_WR); end
      OP_RTYPE: begin ph_q.push_back(PH_RX); ph_q.push_back(PH_RWB); end
      OP_BEQ:   ph_q.push_back(PH_BEQ);
      OP_ADDI:  begin ph_q.push_back(PH_AX); ph_q.push_back(PH_AWB); end
      OP_J:     ph_q.push_back(PH_J);
      default:  ph_q.push_back(PH_EXC);
    endcase
  endfunction

  // Entry/exit: posedge+1 with the trap DUT in FETCH. sf/sm = ready-low cycles in FETCH/memory.
  task automatic exec_instr(input logic [5:0] o, input int sf, input int sm, input logic z);
    int n = 0;
    build_phases(o);
    obs_q.delete(); exp_q.delete(); obs0_q.delete();
    foreach (ph_q[p]) begin
      logic waits, rdy;
      int k = 0;
      waits = (ph_q[p] == PH_F) || (ph_q[p] == PH_RD) || (ph_q[p] == PH_WR);
      do begin
        rdy = waits ? (k >= ((ph_q[p] == PH_F) ? sf : sm)) : 1'($urandom_range(0, 1));
        op = o; zero = z; mem_ready = rdy;
        #1;
        obs_q.push_back(obs_vec());
        exp_q.push_back(exp_vec(ph_q[p], rdy, z));
        obs0_q.push_back({illegal_op_0, dbg_state_0});
        n++; k++;
        @(posedge clk); #1;
      end while (waits && !rdy);
    end
    mem_ready = 1'b0;
    #1;
    lat_obs = (dbg_state == ST_FETCH) ? n : -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] en;
    reset = 1'b1; mem_ready = 1'b1; op = OP_LW; zero = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    en = {irwrite, memwrite, regwrite, pcen, illegal_op};
    n_total++;
    if (en !== 5'b0 || dbg_state !== 4'(ST_FETCH))
      $display("FAIL reset_hold: enables=%b state=%0d, want 00000 state=%0d", en, dbg_state, ST_FETCH);
    else n_pass++;
    reset = 1'b0; #1;
    n_total++;
    if (irwrite !== 1'b1 || pcen !== 1'b1)
      $display("FAIL reset_release_fetch: irwrite=%b pcen=%b, want 1 1", irwrite, pcen);
    else n_pass++;
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    mem_ready = 1'b0; #1;
    n_total++;
    if (dbg_state !== 4'(ST_MEMRD))
      $display("FAIL lw_reach_memrd: state=%0d, want %0d", dbg_state, ST_MEMRD);
    else n_pass++;
    reset = 1'b1; #1;
    for (int c = 0; c < 2; c++) begin
      en = {irwrite, memwrite, regwrite, pcen, illegal_op};
      n_total++;
      if (en !== 5'b0) $display("FAIL reset_mid_lw cyc%0d: enables=%b, want 00000", c, en);
      else n_pass++;
      @(posedge clk); #1;
      mem_ready = 1'b1; #1;
    end
    reset = 1'b0; mem_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (dbg_state !== 4'(ST_FETCH) || regwrite !== 1'b0)
        $display("FAIL after_abort cyc%0d: state=%0d regwrite=%b, want %0d 0", c, dbg_state, regwrite, ST_FETCH);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    do_reset();
    exec_instr(OP_RTYPE, 0, 0, 1'($urandom_range(0, 1)));
    foreach (obs_q[i]) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL rtype cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (lat_obs !== 4) $display("FAIL rtype_latency: got %0d, want 4", lat_obs);
    else n_pass++;
  endtask

  task automatic test_lw_stall();
    int wb = 0;
    do_reset();
    exec_instr(OP_LW, 0, 2, 1'b0);
    foreach (obs_q[i]) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL lw_stall cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
      if (obs_q[i][15] && obs_q[i][13]) wb++;
    end
    n_total++;
    if (lat_obs !== 7 || wb !== 1)
      $display("FAIL lw_stall_latency: got %0d cycles %0d writebacks, want 7 1", lat_obs, wb);
    else n_pass++;
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      exec_instr(OP_BEQ, 0, 0, 1'(z));
      n_total++;
      if (obs_q[2] !== exp_q[2]) $display("FAIL beq_zero%0d: got %h, want %h", z, obs_q[2], exp_q[2]);
      else n_pass++;
      n_total++;
      if (lat_obs !== 3) $display("FAIL beq_latency zero%0d: got %0d, want 3", z, lat_obs);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    exec_instr(OP_J, 3, 0, 1'b0);
    foreach (obs_q[i]) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL fetch_stall cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (lat_obs !== 6) $display("FAIL fetch_stall_latency: got %0d, want 6", lat_obs);
    else n_pass++;
  endtask

  task automatic test_illegal();
    int pulses = 0;
    do_reset();
    exec_instr(6'b111111, 0, 0, 1'b0);
    foreach (obs_q[i]) begin
      n_total++;
      if (obs_q[i] !== exp_q[i]) $display("FAIL illegal_trap cyc%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
      if (obs0_q[i][4]) pulses++;
    end
    n_total++;
    if (pulses !== 0 || obs0_q[2][3:0] !== 4'(ST_FETCH))
      $display("FAIL illegal_notrap: pulses=%0d state=%0d, want 0 %0d", pulses, obs0_q[2][3:0], ST_FETCH);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] ops [9] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J,
                           6'b111111, 6'b000001, 6'b110000};
    do_reset();
    for (int t = 0; t < 40; t++) begin
      logic [5:0] o;
      int sf, sm, errs;
      o  = ops[$urandom_range(0, 8)];
      sf = $urandom_range(0, 2);
      sm = $urandom_range(0, 2);
      exec_instr(o, sf, sm, 1'($urandom_range(0, 1)));
      errs = 0;
      foreach (obs_q[i]) begin
        n_total++;
        if (obs_q[i] !== exp_q[i]) begin
          if (errs == 0) $display("FAIL random t%0d op=%b cyc%0d: got %h, want %h", t, o, i, obs_q[i], exp_q[i]);
          errs++;
        end else n_pass++;
      end
      n_total++;
      if (lat_obs !== lat_base(o) + sf + (((o == OP_LW) || (o == OP_SW)) ? sm : 0))
        $display("FAIL random_latency t%0d op=%b: got %0d, want %0d", t, o, lat_obs,
                 lat_base(o) + sf + (((o == OP_LW) || (o == OP_SW)) ? sm : 0));
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_fetch_stall();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
